// File: rtl/rs232_byte_rx_pkg.sv
// Shared definitions for the RS-232 receive path: FSM states, default line settings
// and the baud divider helpers also used by the transmit side.
package rs232_byte_rx_pkg;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;

    typedef enum logic [2:0] {
        StWaitIdle = 3'd0,
        StIdle     = 3'd1,
        StStart    = 3'd2,
        StData     = 3'd3,
        StStop     = 3'd4
    } rx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned baud_half(input int unsigned clk_hz, input int unsigned baud);
        return baud_div(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/rs232_byte_rx_baud_counter.sv
// Bit-period counter: counts 0..limit-1 and flags the last count, where the limit is
// either a full bit (DIV) or half a bit (HALF).
module rs232_byte_rx_baud_counter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DIV   = 434,
    parameter int unsigned HALF  = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic half_sel,
    output logic tick
);

    localparam logic [CNT_W-1:0] LIM_DIV  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LIM_HALF = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == (half_sel ? LIM_HALF : LIM_DIV));

    // Restarting on tick lets DATA time consecutive bits without a state change.
    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rs232_byte_rx.sv
// 8N1 serial byte receiver: synchronises RXD, validates the start bit at mid-bit,
// samples eight data bits LSB first and checks the stop bit.
module rs232_byte_rx
    import rs232_byte_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD,
    parameter int unsigned CNT_W  = 16
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] RS_DATAOUT,
    output logic       RS_DONE,
    output logic       RS_FRAME_ERR,
    output logic       RS_BUSY
);

    localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD);
    localparam int unsigned HALF = baud_half(CLK_HZ, BAUD);

    logic [1:0] sync_q;
    logic       rx_s;
    rx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic       clr;
    logic       half_sel;
    logic       tick;

    assign rx_s = sync_q[1];

    rs232_byte_rx_baud_counter #(
        .CNT_W (CNT_W),
        .DIV   (DIV),
        .HALF  (HALF)
    ) u_baud_counter (
        .clk      (CLK_50MHZ),
        .rst      (RST),
        .clr      (clr),
        .half_sel (half_sel),
        .tick     (tick)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            sync_q    <= 2'b11;
            state_q   <= StWaitIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], RXD};
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        half_sel  = 1'b0;
        clr       = 1'b0;

        unique case (state_q)
            // The line must read high for half a bit, so the reset-loaded synchroniser
            // ones cannot release a line that is really held low.
            StWaitIdle: begin
                half_sel = 1'b1;
                if (!rx_s) begin
                    clr = 1'b1;
                end else if (tick) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                clr = 1'b1;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                half_sel = 1'b1;
                if (tick) begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitIdle;
                    end
                end
            end
            default: begin
                state_d = StWaitIdle;
            end
        endcase

        if (state_d != state_q) begin
            clr = 1'b1;
        end
    end

    assign RS_DATAOUT   = data_q;
    assign RS_DONE      = done_q;
    assign RS_FRAME_ERR = ferr_q;
    assign RS_BUSY      = (state_q != StIdle);

endmodule
